hamming_decode_pipe: RTL and testbench

- Pipelined single-error-correcting decoder for the 38-bit Hamming codeword written into the SyncFIFO.
- Sits on the FIFO read side: takes the stored codeword, computes a 6-bit syndrome, corrects any single-bit error and returns the 32-bit raw data.
- Uses a valid/ready handshake with a 2-stage pipeline.
- Keeps saturating counters of corrected and uncorrectable words for status readout.

---
 rtl/hamming_decode_pipe.sv | 113 +++++++++++
 tb/tb_hamming_decode_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decode_pipe.sv
// rtl/hamming_decode_pipe.sv - two-stage single-error-correcting decoder for 38-bit Hamming codewords
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; enc_in is the 38-bit stored codeword
//   out_valid/out_ready  output handshake; dec_data is the corrected 32-bit word
//   out_corr             a single-bit error (data or parity bit) was corrected
//   out_err              syndrome above 38, data passed through uncorrected
//   cnt_clr              synchronous clear of both status counters
//   corr_cnt, err_cnt    saturating counts of delivered corrected / uncorrectable words
module hamming_decode_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [37:0]      enc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      dec_data,
  output logic             out_corr,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic        adv;
  logic        s1_valid;
  logic [37:0] s1_code;
  logic [5:0]  s1_syn;
  logic [5:0]  syn;
  logic [37:0] fixed;
  logic [31:0] ext;
  logic        corr_n;
  logic        err_n;

  // Whole pipeline moves together; only a stalled, full output register blocks it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Syndrome bit k covers every codeword position (index+1) with bit k set.
  always_comb begin
    syn = '0;
    for (int i = 0; i < 38; i++) begin
      for (int k = 0; k < 6; k++) begin
        if ((((i + 1) >> k) % 2) == 1) begin
          syn[k] = syn[k] ^ enc_in[i];
        end
      end
    end
  end

  // A syndrome equal to a position names the bit to flip; 39..63 name no bit.
  always_comb begin
    fixed  = s1_code;
    corr_n = 1'b0;
    err_n  = 1'b0;
    if (s1_syn > 6'd38) begin
      err_n = 1'b1;
    end else if (s1_syn != 6'd0) begin
      corr_n = 1'b1;
      for (int i = 0; i < 38; i++) begin
        if (s1_syn == 6'(i + 1)) begin
          fixed[i] = ~s1_code[i];
        end
      end
    end
  end

  // Data bits occupy every non-power-of-two position, in ascending order.
  assign ext = {fixed[37:32], fixed[30:16], fixed[14:8], fixed[6:4], fixed[2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_code   <= '0;
      s1_syn    <= '0;
      out_valid <= 1'b0;
      dec_data  <= '0;
      out_corr  <= 1'b0;
      out_err   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_code   <= enc_in;
      s1_syn    <= syn;
      out_valid <= s1_valid;
      dec_data  <= ext;
      out_corr  <= corr_n & s1_valid;
      out_err   <= err_n & s1_valid;
    end
  end

  // Counters see only delivered words; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
      err_cnt  <= '0;
    end else if (cnt_clr) begin
      corr_cnt <= '0;
      err_cnt  <= '0;
    end else if (out_valid && out_ready) begin
      if (out_corr && (corr_cnt != {CNT_W{1'b1}})) begin
        corr_cnt <= corr_cnt + CNT_W'(1);
      end
      if (out_err && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming_decode_pipe.sv
// tb/tb_hamming_decode_pipe.sv - scoreboard bench for hamming_decode_pipe
module tb_hamming_decode_pipe;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [37:0]      enc_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      dec_data;
  logic             out_corr;
  logic             out_err;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] err_cnt;

  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  hamming_decode_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .enc_in(enc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .dec_data(dec_data), .out_corr(out_corr), .out_err(out_err),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [37:0] enc(input logic [31:0] d);
    logic [37:0] c;
    logic        p;
    int          j;
    c = '0;
    j = 0;
    for (int i = 0; i < 38; i++) begin
      if (((i + 1) & i) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      p = 1'b0;
      for (int i = 0; i < 38; i++) begin
        if ((((i + 1) >> k) % 2) == 1) p = p ^ c[i];
      end
      c[(1 << k) - 1] = p;
    end
    return c;
  endfunction

  // Scoreboard: every delivered word must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_out: observed data %0h expected no word", dec_data);
        end
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("dec_data", dec_data, x.d);
        chk("out_corr", out_corr, x.c);
        chk("out_err",  out_err,  x.e);
      end
    end
  end

  task automatic send(input logic [37:0] code, input logic [31:0] d, input logic c, input logic e);
    int t;
    in_valid = 1'b1;
    enc_in   = code;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    exp_q.push_back({d, c, e});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    logic [37:0] w [4];
    logic [31:0] d [4];
    logic [31:0] rd;
    logic [37:0] code;
    logic        fl;
    int          t;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dec_data", dec_data, 0);
    chk("rst_out_corr", out_corr, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_corr_cnt", corr_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean word
    send(38'h0, 32'h0, 1'b0, 1'b0);
    drain();
    chk("clean_corr_cnt", corr_cnt, 0);
    chk("clean_err_cnt", err_cnt, 0);

    // Data-bit error at index 2 (S=3) must be restored to 0
    send(38'h4, 32'h0, 1'b1, 1'b0);
    drain();
    chk("bit2_corr_cnt", corr_cnt, 1);

    // Parity-bit error (S=1)
    send(38'h1, 32'h0, 1'b1, 1'b0);
    drain();
    chk("par_corr_cnt", corr_cnt, 2);

    // Uncorrectable syndrome S=39
    send((38'h1 << 37) | 38'h1, 32'h8000_0000, 1'b0, 1'b1);
    drain();
    chk("s39_err_cnt", err_cnt, 1);
    chk("s39_corr_cnt", corr_cnt, 2);

    // Backpressure: stall 3 cycles after the first output
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      w[i] = enc(d[i]);
    end
    in_valid = 1'b1;
    enc_in = w[0];
    exp_q.push_back({d[0], 1'b0, 1'b0});
    @(posedge clk);
    #1 enc_in = w[1];
    exp_q.push_back({d[1], 1'b0, 1'b0});
    @(posedge clk);
    #1 enc_in = w[2];
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_dec_data", dec_data, d[0]);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(w[2], d[2], 1'b0, 1'b0);
    send(w[3], d[3], 1'b0, 1'b0);
    drain();

    // Saturation at 2^CNT_W-1
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("clr_corr_cnt", corr_cnt, 0);
    chk("clr_err_cnt", err_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      rd = $urandom;
      code = enc(rd);
      code[i % 38] = ~code[i % 38];
      send(code, rd, 1'b1, 1'b0);
    end
    drain();
    chk("sat_corr_cnt", corr_cnt, 15);

    // Clear overrides a same-cycle increment
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    code = enc(32'h1234_5678) ^ (38'h1 << 20);
    send(code, 32'h1234_5678, 1'b1, 1'b0);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("clr_wait_out_valid", out_valid, 1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("clr_vs_inc_corr_cnt", corr_cnt, 0);
    send(code, 32'h1234_5678, 1'b1, 1'b0);
    drain();
    chk("after_clr_corr_cnt", corr_cnt, 1);

    // Reset with two words in flight
    in_valid = 1'b1;
    enc_in = enc(32'hdead_beef);
    @(posedge clk);
    #1 enc_in = enc(32'hcafe_f00d);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_corr_cnt", corr_cnt, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postrst_out_valid", out_valid, 0);
    end

    // Randomized sweep with 0 or 1 flipped bits
    @(posedge clk);
    #1;
    for (int i = 0; i < 30; i++) begin
      rd = $urandom;
      code = enc(rd);
      fl = 1'($urandom_range(1));
      if (fl) code[$urandom_range(37)] ^= 1'b1;
      send(code, rd, fl, 1'b0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
